pipelined_shifter: RTL and testbench

Parametrised, pipelined barrel shifter for the ALU datapath. It is the successor to the single-cycle combinational SLL shifter.
- Adds SRL, SRA, ROL and ROR modes.
- Generic data width.
- Configurable number of register stages.
- valid/ready handshake on input and output, so the ALU and multi-cycle control can stall it.
It sits beside the ALU/multiplier and feeds the ALU result mux.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/shifter_level.sv | 29 ++
 rtl/pipelined_shifter.sv | 142 ++++++++++++++
 tb/tb_pipelined_shifter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU shifter definitions: shift op encodings, default width and
// helpers used to place mux levels into pipeline stages.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [2:0] {
    SH_SLL = 3'b000,
    SH_SRL = 3'b001,
    SH_SRA = 3'b010,
    SH_ROL = 3'b011,
    SH_ROR = 3'b100
  } sh_op_e;

  // Encodings 101..111 are reserved and flagged as op errors.
  localparam logic [2:0] SH_ILLEGAL_MIN = 3'b101;

  function automatic logic op_illegal(input logic [2:0] op);
    return op >= SH_ILLEGAL_MIN;
  endfunction

  function automatic int level_stage(input int k, input int stages, input int shw);
    return (k * stages) / shw;
  endfunction

endpackage

// File: rtl/shifter_level.sv
// One barrel-shifter mux level: shifts or rotates by DIST when en_i is set.
module shifter_level
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [2:0]       op_i,
  input  logic             en_i,
  input  logic             sign_i,
  output logic [WIDTH-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    if (en_i) begin
      case (op_i)
        SH_SLL:  data_o = {data_i[WIDTH-1-DIST:0], {DIST{1'b0}}};
        SH_SRL:  data_o = {{DIST{1'b0}}, data_i[WIDTH-1:DIST]};
        SH_SRA:  data_o = {{DIST{sign_i}}, data_i[WIDTH-1:DIST]};
        SH_ROL:  data_o = {data_i[WIDTH-1-DIST:0], data_i[WIDTH-1:WIDTH-DIST]};
        SH_ROR:  data_o = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
        default: data_o = data_i;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) with PIPE_STAGES register
// stages, a globally stalled pipe and valid/ready on both sides.
module pipelined_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH       = ALU_WIDTH,
  parameter int PIPE_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dataOut,
  output logic             op_err
);

  localparam int SHW  = $clog2(WIDTH);
  localparam int CTLW = SHW + 5;          // {op[2:0], amt[SHW-1:0], over, sign}
  localparam int LS   = PIPE_STAGES - 1;

  // Handshake: a beat is taken when in_valid && in_ready and a result is
  // handed over when out_valid && out_ready. The whole pipe advances together
  // whenever in_ready is high, so in_ready depends only on the output side.
  logic adv;
  assign in_ready = !out_valid || out_ready;
  assign adv      = in_ready;

  logic             sin_vld  [PIPE_STAGES];
  logic [CTLW-1:0]  sin_ctl  [PIPE_STAGES];
  logic [WIDTH-1:0] sin_dat  [PIPE_STAGES];
  logic [WIDTH-1:0] sout_dat [PIPE_STAGES];
  logic [WIDTH-1:0] lvl_out  [SHW];

  assign sin_vld[0] = in_valid;
  assign sin_dat[0] = dataA;
  assign sin_ctl[0] = {op, dataB[SHW-1:0], |dataB[WIDTH-1:SHW], dataA[WIDTH-1]};

  for (genvar k = 0; k < SHW; k++) begin : g_lvl
    localparam int STG  = level_stage(k, PIPE_STAGES, SHW);
    localparam bit FIRST = (k == 0) || (level_stage(k - 1, PIPE_STAGES, SHW) != STG);
    localparam bit LAST  = (k == SHW - 1) || (level_stage(k + 1, PIPE_STAGES, SHW) != STG);

    logic [WIDTH-1:0] lvl_in;
    if (FIRST) begin : g_first
      assign lvl_in = sin_dat[STG];
    end else begin : g_chain
      assign lvl_in = lvl_out[k-1];
    end

    shifter_level #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_level (
      .data_i (lvl_in),
      .op_i   (sin_ctl[STG][CTLW-1 -: 3]),
      .en_i   (sin_ctl[STG][2+k]),
      .sign_i (sin_ctl[STG][0]),
      .data_o (lvl_out[k])
    );

    if (LAST) begin : g_last
      assign sout_dat[STG] = lvl_out[k];
    end
  end

  for (genvar s = 0; s < LS; s++) begin : g_stg
    logic             vld_q;
    logic [CTLW-1:0]  ctl_q;
    logic [WIDTH-1:0] dat_q;

    always_ff @(posedge clk) begin
      if (!reset) begin
        vld_q <= 1'b0;
      end else if (adv) begin
        vld_q <= sin_vld[s];
      end
    end

    always_ff @(posedge clk) begin
      if (adv) begin
        ctl_q <= sin_ctl[s];
        dat_q <= sout_dat[s];
      end
    end

    assign sin_vld[s+1] = vld_q;
    assign sin_ctl[s+1] = ctl_q;
    assign sin_dat[s+1] = dat_q;
  end

  // Overshift and illegal-op fix-up happens just before the output register.
  logic [2:0]       l_op;
  logic             l_over;
  logic             l_sign;
  logic [WIDTH-1:0] res_d;
  logic             err_d;

  assign l_op   = sin_ctl[LS][CTLW-1 -: 3];
  assign l_over = sin_ctl[LS][1];
  assign l_sign = sin_ctl[LS][0];

  always_comb begin
    res_d = sout_dat[LS];
    err_d = 1'b0;
    if (op_illegal(l_op)) begin
      res_d = '0;
      err_d = sin_vld[LS];
    end else if (l_over) begin
      case (l_op)
        SH_SLL, SH_SRL: res_d = '0;
        SH_SRA:         res_d = {WIDTH{l_sign}};
        default:        res_d = sout_dat[LS];
      endcase
    end
  end

  logic             out_valid_q;
  logic [WIDTH-1:0] dout_q;
  logic             err_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      err_q       <= 1'b0;
    end else if (adv) begin
      out_valid_q <= sin_vld[LS];
      dout_q      <= res_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dataOut   = dout_q;
  assign op_err    = err_q;

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed bench for pipelined_shifter: 32-bit copies with 2, 1 and 5 stages
// share one stimulus stream; a 64-bit, 3-stage copy gets its own sequence.
module tb_pipelined_shifter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  // shared 32-bit stimulus
  logic        in_valid;
  logic [31:0] dataA, dataB;
  logic [2:0]  op;
  logic [32:0] cur_exp;
  logic        in_valid_bc;

  logic        a_in_ready, a_out_valid, a_out_ready, a_err;
  logic [31:0] a_dout;
  logic        b_in_ready, b_out_valid, b_err;
  logic [31:0] b_dout;
  logic        c_in_ready, c_out_valid, c_err;
  logic [31:0] c_dout;

  logic        d_in_valid, d_in_ready, d_out_valid, d_err;
  logic [2:0]  d_op;
  logic [63:0] d_dataA, d_dataB, d_dout;
  logic [64:0] d_cur_exp;

  // B and C only see beats that A actually accepts, so all three get one copy.
  assign in_valid_bc = in_valid && a_in_ready;

  pipelined_shifter #(.WIDTH(32), .PIPE_STAGES(2)) u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .dataA(dataA), .dataB(dataB), .op(op), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .dataOut(a_dout), .op_err(a_err));

  pipelined_shifter #(.WIDTH(32), .PIPE_STAGES(1)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_bc), .in_ready(b_in_ready),
    .dataA(dataA), .dataB(dataB), .op(op), .out_valid(b_out_valid),
    .out_ready(1'b1), .dataOut(b_dout), .op_err(b_err));

  pipelined_shifter #(.WIDTH(32), .PIPE_STAGES(5)) u_c (
    .clk(clk), .reset(reset), .in_valid(in_valid_bc), .in_ready(c_in_ready),
    .dataA(dataA), .dataB(dataB), .op(op), .out_valid(c_out_valid),
    .out_ready(1'b1), .dataOut(c_dout), .op_err(c_err));

  pipelined_shifter #(.WIDTH(64), .PIPE_STAGES(3)) u_d (
    .clk(clk), .reset(reset), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .dataA(d_dataA), .dataB(d_dataB), .op(d_op), .out_valid(d_out_valid),
    .out_ready(1'b1), .dataOut(d_dout), .op_err(d_err));

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // scoreboards: expected {op_err, dataOut} per accepted beat
  logic [32:0] exp_a_q[$];
  logic [32:0] exp_b_q[$];
  logic [32:0] exp_c_q[$];
  logic [64:0] exp_d_q[$];
  int          del_cyc_q[$];

  always @(negedge clk) begin
    if (reset) begin
      if (in_valid && a_in_ready) exp_a_q.push_back(cur_exp);
      if (a_out_valid && a_out_ready) begin
        del_cyc_q.push_back(cyc);
        if (exp_a_q.size() == 0) chk("a_unexpected_out", {32'd0, a_out_valid}, 65'd0);
        else chk("a_out", {32'd0, a_err, a_dout}, {32'd0, exp_a_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (in_valid_bc && b_in_ready) exp_b_q.push_back(cur_exp);
      if (b_out_valid) begin
        if (exp_b_q.size() == 0) chk("b_unexpected_out", {32'd0, b_out_valid}, 65'd0);
        else chk("b_out", {32'd0, b_err, b_dout}, {32'd0, exp_b_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (in_valid_bc && c_in_ready) exp_c_q.push_back(cur_exp);
      if (c_out_valid) begin
        if (exp_c_q.size() == 0) chk("c_unexpected_out", {32'd0, c_out_valid}, 65'd0);
        else chk("c_out", {32'd0, c_err, c_dout}, {32'd0, exp_c_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (d_in_valid && d_in_ready) exp_d_q.push_back(d_cur_exp);
      if (d_out_valid) begin
        if (exp_d_q.size() == 0) chk("d_unexpected_out", {64'd0, d_out_valid}, 65'd0);
        else chk("d_out", {d_err, d_dout}, exp_d_q.pop_front());
      end
    end
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  // Called at #1 after a rising edge; returns #1 after the accepting edge.
  task automatic drive(input vec_t v);
    int n;
    op = v.op; dataA = v.a; dataB = v.b; cur_exp = {v.err, v.exp}; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!a_in_ready && n < 50);
    if (!a_in_ready) chk("drive_timeout", {64'd0, a_in_ready}, 65'd1);
    @(posedge clk); #1;
  endtask

  task automatic drive_d(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic [64:0] e);
    int n;
    d_op = o; d_dataA = a; d_dataB = b; d_cur_exp = e; d_in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!d_in_ready && n < 50);
    if (!d_in_ready) chk("drive_d_timeout", {64'd0, d_in_ready}, 65'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_a_valid"}, {64'd0, a_out_valid}, 65'd0);
    chk({tag, "_a_dout"},  {33'd0, a_dout},      65'd0);
    chk({tag, "_a_err"},   {64'd0, a_err},       65'd0);
    chk({tag, "_a_ready"}, {64'd0, a_in_ready},  65'd1);
    chk({tag, "_b_valid"}, {64'd0, b_out_valid}, 65'd0);
    chk({tag, "_b_dout"},  {33'd0, b_dout},      65'd0);
    chk({tag, "_b_ready"}, {64'd0, b_in_ready},  65'd1);
    chk({tag, "_c_valid"}, {64'd0, c_out_valid}, 65'd0);
    chk({tag, "_c_dout"},  {33'd0, c_dout},      65'd0);
    chk({tag, "_c_ready"}, {64'd0, c_in_ready},  65'd1);
    chk({tag, "_d_valid"}, {64'd0, d_out_valid}, 65'd0);
    chk({tag, "_d_dout"},  {1'b0, d_dout},       65'd0);
    chk({tag, "_d_err"},   {64'd0, d_err},       65'd0);
    chk({tag, "_d_ready"}, {64'd0, d_in_ready},  65'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int la, lb, lc, ld, gaps, stale;

    vecs[0]  = '{3'b000, 32'h0000_0001, 32'd31,        32'h8000_0000, 1'b0};
    vecs[1]  = '{3'b010, 32'h8000_0F00, 32'd4,         32'hF800_00F0, 1'b0};
    vecs[2]  = '{3'b010, 32'h8000_0F00, 32'd40,        32'hFFFF_FFFF, 1'b0};
    vecs[3]  = '{3'b001, 32'h8000_0F00, 32'd32,        32'h0000_0000, 1'b0};
    vecs[4]  = '{3'b100, 32'h1234_5678, 32'd36,        32'h8123_4567, 1'b0};
    vecs[5]  = '{3'b011, 32'h8000_0001, 32'd1,         32'h0000_0003, 1'b0};
    vecs[6]  = '{3'b000, 32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF, 1'b0};
    vecs[7]  = '{3'b001, 32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF, 1'b0};
    vecs[8]  = '{3'b010, 32'h7000_0000, 32'd31,        32'h0000_0000, 1'b0};
    vecs[9]  = '{3'b010, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 1'b0};
    vecs[10] = '{3'b011, 32'h1234_5678, 32'd8,         32'h3456_7812, 1'b0};
    vecs[11] = '{3'b100, 32'h0000_00FF, 32'd4,         32'hF000_000F, 1'b0};
    vecs[12] = '{3'b001, 32'hFFFF_FFFF, 32'd31,        32'h0000_0001, 1'b0};
    vecs[13] = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[14] = '{3'b011, 32'h8765_4321, 32'd32,        32'h8765_4321, 1'b0};
    vecs[15] = '{3'b111, 32'hFFFF_FFFF, 32'd5,         32'h0000_0000, 1'b1};
    vecs[16] = '{3'b101, 32'h0000_1234, 32'd0,         32'h0000_0000, 1'b1};
    vecs[17] = '{3'b000, 32'h0000_000F, 32'd4,         32'h0000_00F0, 1'b0};
    vecs[18] = '{3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[19] = '{3'b010, 32'h9000_0000, 32'h8000_0001, 32'hFFFF_FFFF, 1'b0};
    vecs[20] = '{3'b100, 32'h0000_0001, 32'h8000_0001, 32'h8000_0000, 1'b0};

    reset = 1'b0; in_valid = 1'b0; dataA = '0; dataB = '0; op = '0; cur_exp = '0;
    a_out_ready = 1'b1;
    d_in_valid = 1'b0; d_dataA = '0; d_dataB = '0; d_op = '0; d_cur_exp = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_idle("rst");
    @(posedge clk); #1;

    // first-beat latency on each 32-bit copy
    drive(vecs[0]);
    in_valid = 1'b0;
    la = 0; lb = 0; lc = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (a_out_valid && la == 0) la = n;
      if (b_out_valid && lb == 0) lb = n;
      if (c_out_valid && lc == 0) lc = n;
    end
    chk("lat_a", la, 2);
    chk("lat_b", lb, 1);
    chk("lat_c", lc, 5);
    @(posedge clk); #1;

    // table back-to-back: results must leave on consecutive cycles
    del_cyc_q.delete();
    for (int i = 1; i < NV; i++) drive(vecs[i]);
    in_valid = 1'b0;
    idle(10);
    chk("b2b_count", del_cyc_q.size(), NV - 1);
    gaps = 0;
    for (int i = 1; i < del_cyc_q.size(); i++)
      if (del_cyc_q[i] != del_cyc_q[i-1] + 1) gaps++;
    chk("b2b_gaps", gaps, 0);

    // stall with A full: hold for 3 cycles, output must not move
    a_out_ready = 1'b0;
    drive(vecs[12]);
    drive(vecs[13]);
    op = vecs[14].op; dataA = vecs[14].a; dataB = vecs[14].b;
    cur_exp = {vecs[14].err, vecs[14].exp}; in_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("stall_in_ready", {64'd0, a_in_ready}, 65'd0);
      chk("stall_out_valid", {64'd0, a_out_valid}, 65'd1);
      chk("stall_dout", {32'd0, a_err, a_dout}, {32'd0, vecs[12].err, vecs[12].exp});
      @(posedge clk); #1;
    end
    a_out_ready = 1'b1;
    drive(vecs[14]);
    in_valid = 1'b0;
    idle(10);
    chk("a_q_empty", exp_a_q.size(), 0);
    chk("b_q_empty", exp_b_q.size(), 0);
    chk("c_q_empty", exp_c_q.size(), 0);

    // 64-bit copy
    drive_d(3'b000, 64'h1, 64'd63, {1'b0, 64'h8000_0000_0000_0000});
    d_in_valid = 1'b0;
    ld = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (d_out_valid && ld == 0) ld = n;
    end
    chk("lat_d", ld, 3);
    @(posedge clk); #1;
    drive_d(3'b010, 64'h8000_0000_0000_0000, 64'd64, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
    drive_d(3'b100, 64'h0123_4567_89AB_CDEF, 64'd68, {1'b0, 64'hF012_3456_789A_BCDE});
    drive_d(3'b001, 64'hFFFF_FFFF_0000_0000, 64'd32, {1'b0, 64'h0000_0000_FFFF_FFFF});
    drive_d(3'b011, 64'h8000_0000_0000_0001, 64'd63, {1'b0, 64'hC000_0000_0000_0000});
    drive_d(3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, {1'b1, 64'h0});
    drive_d(3'b000, 64'h0000_0000_0000_00FF, 64'd0, {1'b0, 64'h0000_0000_0000_00FF});
    d_in_valid = 1'b0;
    idle(8);
    chk("d_q_empty", exp_d_q.size(), 0);

    // reset with two beats in flight on every copy
    drive(vecs[5]);
    drive(vecs[6]);
    drive_d(3'b000, 64'h3, 64'd2, {1'b0, 64'hC});
    drive_d(3'b001, 64'hF0, 64'd4, {1'b0, 64'hF});
    in_valid = 1'b0; d_in_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_a_q.delete(); exp_b_q.delete(); exp_c_q.delete(); exp_d_q.delete();
    @(negedge clk);
    check_idle("midrst");
    stale = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (a_out_valid || b_out_valid || c_out_valid || d_out_valid) stale++;
    end
    chk("no_stale", stale, 0);
    @(posedge clk); #1;

    // pipe still works after the mid-flight reset
    drive(vecs[4]);
    drive(vecs[15]);
    drive(vecs[17]);
    in_valid = 1'b0;
    idle(10);
    chk("post_a_q_empty", exp_a_q.size(), 0);
    chk("post_c_q_empty", exp_c_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
